sync_fifo: RTL

// - Single-clock FIFO for buffering inside one clock domain, e.g. the command path after the
//   CDC FIFO and the rasteriser/pixel pipelines.
// - Generalises the earlier FIFO: selectable first-word-fall-through (FWFT) or registered

---
 rtl/sync_fifo_if.sv | 33 +++
 rtl/sync_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_if.sv
// Handshake bundle for sync_fifo: write port, read port, level flags and sticky error flags.
// The FIFO side uses the slave modport; the producer/consumer side uses master.
interface sync_fifo_if #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 16
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic                  wr_full;
  logic                  wr_almost_full;
  logic                  rd_en;
  logic [WIDTH-1:0]      rd_data;
  logic                  rd_empty;
  logic                  rd_almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
    input  count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output wr_full, wr_almost_full, rd_data, rd_empty, rd_almost_empty,
    output count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard (registered) or first-word-fall-through read data,
// full pass-through on simultaneous read/write, threshold flags and sticky error flags.

module sync_fifo_chk #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input logic                  clk,
  input logic                  rst,
  input logic [ADDR_WIDTH:0]   wr_ptr,
  input logic [ADDR_WIDTH:0]   rd_ptr,
  input logic [ADDR_WIDTH:0]   count
);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  a_count_range: assert property (@(posedge clk) disable iff (rst) count <= DEPTH_CNT);
  a_ptr_count:   assert property (@(posedge clk) disable iff (rst) (wr_ptr - rd_ptr) == count);
endmodule

module sync_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter bit FWFT       = 1'b0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [ADDR_WIDTH:0] wr_ptr_r;
  logic [ADDR_WIDTH:0] rd_ptr_r;
  logic [ADDR_WIDTH:0] count_r;
  logic                overflow_r;
  logic                underflow_r;

  logic [ADDR_WIDTH:0] wr_ptr_next_s;
  logic [ADDR_WIDTH:0] rd_ptr_next_s;
  logic [ADDR_WIDTH:0] count_next_s;
  logic                overflow_next_s;
  logic                underflow_next_s;
  logic                full_s;
  logic                empty_s;
  logic                rd_acc_s;
  logic                wr_acc_s;

  // Acceptance decode; a read on a full FIFO frees the slot the write needs.
  always_comb begin
    full_s   = (count_r == DEPTH_CNT);
    empty_s  = (count_r == '0);
    rd_acc_s = bus.rd_en && !empty_s;
    wr_acc_s = bus.wr_en && (!full_s || rd_acc_s);
  end

  // Next-state for pointers, occupancy and sticky errors; a set event beats err_clr.
  always_comb begin
    wr_ptr_next_s    = wr_ptr_r;
    rd_ptr_next_s    = rd_ptr_r;
    count_next_s     = count_r;
    overflow_next_s  = overflow_r;
    underflow_next_s = underflow_r;

    if (wr_acc_s) begin
      wr_ptr_next_s = wr_ptr_r + ONE_CNT;
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end

    if (rd_acc_s) begin
      rd_ptr_next_s = rd_ptr_r + ONE_CNT;
    end else begin
      rd_ptr_next_s = rd_ptr_r;
    end

    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_next_s = count_r + ONE_CNT;
      2'b01:   count_next_s = count_r - ONE_CNT;
      default: count_next_s = count_r;
    endcase

    if (bus.wr_en && !wr_acc_s) begin
      overflow_next_s = 1'b1;
    end else if (bus.err_clr) begin
      overflow_next_s = 1'b0;
    end else begin
      overflow_next_s = overflow_r;
    end

    if (bus.rd_en && empty_s) begin
      underflow_next_s = 1'b1;
    end else if (bus.err_clr) begin
      underflow_next_s = 1'b0;
    end else begin
      underflow_next_s = underflow_r;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_next_s;
      rd_ptr_r    <= rd_ptr_next_s;
      count_r     <= count_next_s;
      overflow_r  <= overflow_next_s;
      underflow_r <= underflow_next_s;
    end
  end

  // Storage array; contents survive reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign bus.rd_data = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_r;

      // Registered read port; holds its value when no read is accepted.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_r <= '0;
        end else if (rd_acc_s) begin
          rd_data_r <= mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
        end else begin
          rd_data_r <= rd_data_r;
        end
      end

      assign bus.rd_data = rd_data_r;
    end
  endgenerate

  assign bus.count           = count_r;
  assign bus.wr_full         = full_s;
  assign bus.rd_empty        = empty_s;
  assign bus.wr_almost_full  = (count_r >= AF_CNT);
  assign bus.rd_almost_empty = (count_r <= AE_CNT);
  assign bus.overflow        = overflow_r;
  assign bus.underflow       = underflow_r;

  sync_fifo_chk #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_chk (
    .clk    (clk),
    .rst    (rst),
    .wr_ptr (wr_ptr_r),
    .rd_ptr (rd_ptr_r),
    .count  (count_r)
  );
endmodule
